// File: rtl/button_event_arbiter.sv
// Merges debounced button press pulses into one ordered event stream:
// per-bit sync + rising-edge detect, pending latch, round-robin grant, small FIFO.
module button_event_arbiter #(
  parameter int N_BUTTONS  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] btn_pulse,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [IDX_W-1:0]     evt_idx,
  output logic [N_BUTTONS-1:0] pending,
  output logic                 overflow,
  input  logic                 clr_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [N_BUTTONS-1:0] s1_reg, s2_reg, s3_reg;
  logic [N_BUTTONS-1:0] rise, grant_vec, lost;
  logic [IDX_W-1:0]     rr_ptr_reg;
  logic [IDX_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic                 grant_valid, pop;
  logic [IDX_W-1:0]     grant_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_BUTTONS; gi++) begin : g_bit
      assign rise[gi]      = s2_reg[gi] & ~s3_reg[gi];
      assign grant_vec[gi] = grant_valid && (grant_idx == IDX_W'(gi));
      assign lost[gi]      = rise[gi] & pending[gi] & ~grant_vec[gi];
    end
  endgenerate

  assign pop        = evt_valid && evt_ready;
  assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

  // Walk the search order backwards so the first candidate after rr_ptr wins.
  always_comb begin
    int j;
    j           = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (count_reg < CNT_W'(FIFO_DEPTH)) begin
      for (int k = N_BUTTONS; k >= 1; k--) begin
        j = int'(rr_ptr_reg) + k;
        if (j >= N_BUTTONS) j = j - N_BUTTONS;
        if (pending[j]) begin
          grant_valid = 1'b1;
          grant_idx   = IDX_W'(j);
        end
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({grant_valid, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (grant_valid) mem[wr_ptr_reg] <= grant_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_reg     <= '0;
      s2_reg     <= '0;
      s3_reg     <= '0;
      pending    <= '0;
      overflow   <= 1'b0;
      rr_ptr_reg <= IDX_W'(N_BUTTONS - 1);
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      evt_valid  <= 1'b0;
      evt_idx    <= '0;
    end else begin
      s1_reg    <= btn_pulse;
      s2_reg    <= s1_reg;
      s3_reg    <= s2_reg;
      pending   <= (pending & ~grant_vec) | rise;
      if (|lost)             overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
      if (grant_valid) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        rr_ptr_reg <= grant_idx;
      end
      if (pop) rd_ptr_reg <= rd_ptr_inc;
      count_reg <= count_next;
      evt_valid <= (count_next != '0);
      // Track the next head; an empty FIFO keeps the last index shown.
      if (pop) begin
        if (count_reg > CNT_W'(1)) evt_idx <= mem[rd_ptr_inc];
        else if (grant_valid)      evt_idx <= grant_idx;
      end else if (count_reg == '0 && grant_valid) begin
        evt_idx <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench: hand-computed vector table, directed corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_button_event_arbiter;
  localparam int N = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_pulse;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_idx;
  logic [3:0] pending;
  logic       overflow;
  logic       clr_overflow;

  button_event_arbiter #(.N_BUTTONS(N), .FIFO_DEPTH(D), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_pulse(btn_pulse), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_idx(evt_idx), .pending(pending),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_model = 0;
  int popped[$];

  // reference model state
  logic [3:0] hist [3];
  logic [3:0] m_pend;
  int         m_q[$];
  int         m_rr;
  logic       m_ovf;
  int         m_idx;

  typedef struct {
    logic r; logic [3:0] b; logic rdy; logic c;
    logic v; logic [1:0] idx; logic [3:0] p; logic o;
  } vec_t;
  vec_t tbl [25];

  task automatic model_step(input logic r, input logic [3:0] b, input logic rdy, input logic c);
    logic [3:0] rise, gmask;
    int g;
    bit pop;
    if (!r) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      m_pend = '0; m_q.delete(); m_rr = N - 1; m_ovf = 0; m_idx = 0;
    end else begin
      rise = hist[1] & ~hist[2];
      g = -1;
      if (m_pend != 0 && m_q.size() < D)
        for (int k = 1; k <= N; k++)
          if (m_pend[(m_rr + k) % N]) begin g = (m_rr + k) % N; break; end
      gmask = (g >= 0) ? 4'(1 << g) : 4'b0;
      pop = (m_q.size() > 0) && rdy;
      if ((rise & m_pend & ~gmask) != 0) m_ovf = 1;
      else if (c) m_ovf = 0;
      m_pend = (m_pend & ~gmask) | rise;
      if (pop) void'(m_q.pop_front());
      if (g >= 0) begin m_q.push_back(g); m_rr = g; end
      if (m_q.size() > 0) m_idx = m_q[0];
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = b;
    end
  endtask

  task automatic check_out(input string name, input logic v, input logic [1:0] idx,
                           input logic [3:0] p, input logic o);
    vectors++;
    if (evt_valid !== v || evt_idx !== idx || pending !== p || overflow !== o) begin
      miscompares++;
      $display("FAIL %s t=%0t actual valid=%b idx=%0d pend=%b ovf=%b required valid=%b idx=%0d pend=%b ovf=%b",
               name, $time, evt_valid, evt_idx, pending, overflow, v, idx, p, o);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic check_order(input string name, input int exp[$]);
    check_val({name, "_count"}, popped.size(), exp.size());
    for (int i = 0; i < exp.size() && i < popped.size(); i++)
      check_val($sformatf("%s_%0d", name, i), popped[i], exp[i]);
  endtask

  // One clock: drive, log the handshake, advance model, check 1ns after the edge.
  task automatic step(input logic r, input logic [3:0] b, input logic rdy, input logic c);
    logic pv, pr;
    logic [1:0] pi;
    rst_n = r; btn_pulse = b; evt_ready = rdy; clr_overflow = c;
    pv = evt_valid; pi = evt_idx; pr = rdy;
    if (r && evt_valid === 1'b1 && rdy) popped.push_back(int'(evt_idx));
    @(posedge clk);
    model_step(r, b, rdy, c);
    #1;
    if (chk_model) begin
      check_out("model", m_q.size() != 0, 2'(m_idx), m_pend, m_ovf);
      if (r && pv === 1'b1 && !pr) begin
        check_val("stall_valid", int'(evt_valid), 1);
        check_val("stall_idx", int'(evt_idx), int'(pi));
      end
    end
  endtask

  task automatic press(input int b, input int hold, input int gap, input logic rdy, input logic c);
    for (int i = 0; i < hold; i++) step(1'b1, 4'(1 << b), rdy, c);
    for (int i = 0; i < gap; i++)  step(1'b1, 4'b0, rdy, c);
  endtask

  initial begin
    logic [3:0] rb;
    tbl[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[1]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[2]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[3]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0};
    tbl[4]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0};
    tbl[5]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0};
    tbl[6]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[8]  = '{1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[9]  = '{1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[10] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1011, 1'b0};
    tbl[11] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1010, 1'b0};
    tbl[12] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1000, 1'b0};
    tbl[13] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0};
    tbl[14] = '{1'b1, 4'b1010, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0};
    tbl[15] = '{1'b1, 4'b1010, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0};
    tbl[16] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1010, 1'b0};
    tbl[17] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1000, 1'b0};
    tbl[18] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1000, 1'b0};
    tbl[19] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1000, 1'b0};
    tbl[20] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b0};
    tbl[21] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0};
    tbl[22] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b0};
    tbl[23] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0};
    tbl[24] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0};

    rst_n = 1'b0; btn_pulse = '0; evt_ready = 1'b0; clr_overflow = 1'b0;

    // table: single-press latency, simultaneous presses, round-robin order
    for (int i = 0; i < 25; i++) begin
      step(tbl[i].r, tbl[i].b, tbl[i].rdy, tbl[i].c);
      check_out($sformatf("table_row%0d", i), tbl[i].v, tbl[i].idx, tbl[i].p, tbl[i].o);
    end

    chk_model = 1;
    // backlog beyond FIFO depth, then overflow set/clear behaviour
    step(1'b0, 4'b0, 1'b0, 1'b0);
    press(0, 3, 7, 1'b0, 1'b0); press(1, 3, 7, 1'b0, 1'b0);
    press(2, 3, 7, 1'b0, 1'b0); press(3, 3, 7, 1'b0, 1'b0);
    press(0, 3, 7, 1'b0, 1'b0); press(1, 3, 7, 1'b0, 1'b0);
    check_val("backlog_pending", int'(pending), 3);
    check_val("backlog_overflow", int'(overflow), 0);
    check_val("backlog_head", int'(evt_idx), 0);
    press(0, 3, 10, 1'b0, 1'b0);
    check_val("ovf_sticky", int'(overflow), 1);
    step(1'b1, 4'b0, 1'b0, 1'b1);
    check_val("ovf_cleared", int'(overflow), 0);
    press(1, 3, 7, 1'b0, 1'b1);
    popped.delete();
    for (int i = 0; i < 15; i++) step(1'b1, 4'b0, 1'b1, 1'b0);
    check_order("drain_order", '{0, 1, 2, 3, 0, 1});

    // ready toggling every cycle under continuous random presses
    rb = '0;
    for (int i = 0; i < 300; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(5) == 0) rb[b] = ~rb[b];
      step(1'b1, rb, i[0], 1'b0);
    end

    // reset with events queued and one pending
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0, 1'b1, 1'b1);
    press(0, 2, 4, 1'b0, 1'b0); press(1, 2, 4, 1'b0, 1'b0); press(2, 2, 4, 1'b0, 1'b0);
    press(3, 3, 0, 1'b0, 1'b0);
    step(1'b0, 4'b0, 1'b0, 1'b0);
    check_out("mid_reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    popped.delete();
    press(3, 2, 8, 1'b1, 1'b0);
    check_order("after_reset", '{3});

    // random traffic with occasional clears and resets
    rb = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) rb[b] = ~rb[b];
      step(($urandom_range(400) != 0), rb, ($urandom_range(2) != 0), ($urandom_range(15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
